// File: rtl/pitch_pkg.sv
// Shared constants, types and step arithmetic for the transpose controller.
package pitch_pkg;

  localparam int SHIFT_W = 5;
  localparam logic [SHIFT_W-1:0] SHIFT_MIN     = 5'd0;
  localparam logic [SHIFT_W-1:0] SHIFT_MAX     = 5'd19;
  localparam logic [SHIFT_W-1:0] SHIFT_DEFAULT = 5'd7;

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} rpt_state_t;
  typedef enum logic {DN, UP} step_dir_t;

  // One extra bit so the +/-1 cannot wrap before it is clamped.
  function automatic logic [SHIFT_W-1:0] sat_step(input logic [SHIFT_W-1:0] cur,
                                                  input step_dir_t dir);
    logic [SHIFT_W:0] wide;
    wide = {1'b0, cur};
    if (dir == DN) begin
      if (cur == SHIFT_MIN) return SHIFT_MIN;
      wide = wide - 6'd1;
    end else begin
      wide = wide + 6'd1;
      if (wide > {1'b0, SHIFT_MAX}) return SHIFT_MAX;
    end
    return wide[SHIFT_W-1:0];
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer and debounce counter for one button, with a
// one-cycle pulse on each accepted press.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic sync1, sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Any sample matching the accepted level restarts the count, so a bounce
  // back discards the partial run.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      press <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        cnt   <= '0;
        level <= sync2;
        press <= sync2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/pitch_shift_ctrl.sv
// Transpose-register front end: button conditioning with hold-to-repeat,
// MIDI absolute set, arbitration and between-notes commit.
module pitch_shift_ctrl
  import pitch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_RATE     = 15000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btnl_raw,
  input  logic               btnr_raw,
  input  logic               btnc_raw,
  input  logic               set_valid,
  input  logic [SHIFT_W-1:0] set_value,
  output logic               set_ready,
  input  logic               notes_active,
  output logic [SHIFT_W-1:0] pitchshift,
  output logic               pending,
  output logic               shift_changed
);

  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CNT_W   = $clog2(RPT_MAX + 1);
  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);

  logic press_l, press_r, press_c;
  logic lvl_l, lvl_r, centre_level_unused;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_l (
    .clk(clk), .rst(rst), .raw(btnl_raw), .level(lvl_l), .press(press_l));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_r (
    .clk(clk), .rst(rst), .raw(btnr_raw), .level(lvl_r), .press(press_r));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_c (
    .clk(clk), .rst(rst), .raw(btnc_raw), .level(centre_level_unused), .press(press_c));

  rpt_state_t state, state_nxt;
  step_dir_t  dir, press_dir, step_dir;
  logic [CNT_W-1:0] cnt;
  logic single_press, abort, step;

  assign single_press = press_l ^ press_r;
  assign press_dir    = press_l ? DN : UP;
  assign abort        = (dir == DN) ? (!lvl_l || lvl_r) : (!lvl_r || lvl_l);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (single_press) state_nxt = HOLD;
      HOLD:    if (abort) state_nxt = IDLE;
               else if (cnt == DELAY_LAST) state_nxt = REPEAT;
      REPEAT:  if (abort) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    step     = 1'b0;
    step_dir = dir;
    case (state)
      IDLE: begin
        step     = single_press;
        step_dir = press_dir;
      end
      HOLD:    step = !abort && (cnt == DELAY_LAST);
      REPEAT:  step = !abort && (cnt == RATE_LAST);
      default: step = 1'b0;
    endcase
  end

  // The interval counter restarts whenever a step fires, so one counter
  // serves both the initial delay and the repeat period.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      dir <= UP;
    end else begin
      if (state == IDLE && single_press) dir <= press_dir;
      if (state == IDLE || step) cnt <= '0;
      else                       cnt <= cnt + CNT_W'(1);
    end
  end

  logic set_accept, commit;
  logic [SHIFT_W-1:0] target, target_nxt, pitch_nxt, set_clamped;

  assign set_ready   = !rst;
  assign set_accept  = set_valid && set_ready;
  assign set_clamped = (set_value > SHIFT_MAX) ? SHIFT_MAX : set_value;

  // Centre beats MIDI set beats step; losers are dropped, not queued.
  always_comb begin
    target_nxt = target;
    if (press_c)         target_nxt = SHIFT_DEFAULT;
    else if (set_accept) target_nxt = set_clamped;
    else if (step)       target_nxt = sat_step(target, step_dir);
  end

  assign commit    = !notes_active && (target != pitchshift);
  assign pitch_nxt = commit ? target : pitchshift;

  always_ff @(posedge clk) begin
    if (rst) begin
      target        <= SHIFT_DEFAULT;
      pitchshift    <= SHIFT_DEFAULT;
      pending       <= 1'b0;
      shift_changed <= 1'b0;
    end else begin
      target        <= target_nxt;
      pitchshift    <= pitch_nxt;
      pending       <= (target_nxt != pitch_nxt);
      shift_changed <= commit;
    end
  end

endmodule

// File: doc/pitch_shift_ctrl.md
Name: pitch_shift_ctrl

Overview:
Front-end controller for the transpose (pitch-shift) register, in the panel-control path between the raw board buttons and the note-generation logic.
- Conditions three buttons: synchronize, debounce, edge-detect, hold-to-repeat.
- Accepts absolute shift requests from the MIDI command decoder over a valid/ready handshake.
- Arbitrates all change sources into one target shift.
- Commits the target to the live pitchshift output only between notes, so a sounding note never changes pitch mid-note.

Parameters:
- DEBOUNCE_CYCLES, 1000000: cycles a synchronized button level must be stable before it is accepted (10 ms at 100 MHz).
- REPEAT_DELAY, 50000000: hold time before auto-repeat starts.
- REPEAT_RATE, 15000000: cycles between auto-repeat steps.
- SHIFT_MIN, 0: lowest legal shift.
- SHIFT_MAX, 19: highest legal shift.
- SHIFT_DEFAULT, 7: reset/centre shift (no transposition).

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high; clock clk
- btnl_raw  in  1  asynchronous button, step down
- btnr_raw  in  1  asynchronous button, step up
- btnc_raw  in  1  asynchronous button, return to SHIFT_DEFAULT
- set_valid  in  1  absolute-set request from MIDI decoder
- set_value  in  5  requested shift
- set_ready  out  1  request accepted when set_valid && set_ready
- notes_active  in  1  high while any note is sounding
- pitchshift  out  5  committed shift to note generator
- pending  out  1  target differs from pitchshift
- shift_changed  out  1  one-cycle pulse when pitchshift changes

Behaviour:
- Reset values: pitchshift = SHIFT_DEFAULT, target = SHIFT_DEFAULT, pending = 0, shift_changed = 0, set_ready = 0 during the rst cycle. Debouncers and the repeat FSM return to idle/released.
- Synchronizer: 2-flop per button. The debouncer counter restarts on any level change. The debounced level updates after DEBOUNCE_CYCLES consecutive equal samples.
- Press event: rising edge of the debounced level, one-cycle pulse. Releases generate nothing.
- Repeat FSM, shared by L/R, states IDLE, HOLD, REPEAT:
  - IDLE -> HOLD on a single L or R press. Latch the direction, emit one step, counter = 0.
  - HOLD -> REPEAT when counter reaches REPEAT_DELAY-1. Emit a step and reload the counter.
  - REPEAT emits a step every REPEAT_RATE cycles.
  - Any state -> IDLE when the latched button is released or the opposite button becomes pressed. No step is emitted on that transition.
  - L and R press events in the same cycle: no step; the FSM stays in IDLE.
- Centre: a btnc press event sets target = SHIFT_DEFAULT. No repeat.
- set_ready = 1 in every non-reset cycle. On acceptance, target = min(set_value, SHIFT_MAX); values below SHIFT_MIN cannot occur with SHIFT_MIN = 0.
- Same-cycle priority: rst > btnc > accepted set > L/R step. Lower-priority events that cycle are discarded, not deferred.
- Step arithmetic, saturating:
  - Down at SHIFT_MIN stays at SHIFT_MIN.
  - Up at SHIFT_MAX stays at SHIFT_MAX.
  - Computed in 6 bits to avoid wrap.
- Latency: an event updates target on the next edge.
- Commit: on a cycle where notes_active == 0 and target != pitchshift, pitchshift <= target, with shift_changed = 1 on the following cycle (registered with pitchshift).
  - While notes_active == 1, pitchshift holds and further events keep updating target. Only the latest target is committed.
- pending = (target != pitchshift), registered. It clears the cycle pitchshift commits.
- A step that saturates leaves target unchanged, so no commit and no shift_changed.
- rst mid-hold or mid-debounce aborts everything. A button still held after reset must be re-debounced and produces a fresh press event.

Decomposition:
- Package pitch_pkg:
  - SHIFT_W = 5, SHIFT_MIN, SHIFT_MAX, SHIFT_DEFAULT constants.
  - Repeat FSM state enum {IDLE, HOLD, REPEAT}.
  - A step-direction enum {DN, UP}.
- Sub-module btn_debounce (synchronizer + debounce counter + press-pulse output), instantiated three times. Parameterized by DEBOUNCE_CYCLES.
- Arbitration, saturating math and commit logic stay in the top.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=8):
1. Reset, notes_active=0, tap btnr with 2-cycle bounce, then stable 10 cycles -> exactly one step; pitchshift 7->8, one shift_changed pulse.
2. Hold btnl 60 cycles -> steps at press, +20, +28, +36, +44, +52; pitchshift 7->1. Continue holding to 0; further repeats leave pitchshift at 0 with no shift_changed.
3. notes_active=1, press btnr three times -> target 10, pitchshift stays 7, pending=1. Drop notes_active -> pitchshift=10 next edge, one pulse, pending=0.
4. set_valid with set_value=25 -> pitchshift=19. Same cycle as a btnr press event -> set wins, result 19 from set, step discarded.
5. btnc press with set_valid (set_value=3) same cycle -> target=7. Simultaneous btnl+btnr press from 12 -> stays 12.
6. Assert rst mid-REPEAT with shift 15 -> pitchshift=7, pending=0. Button held through reset -> first new step only after 4+ stable cycles post-reset.
